// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with run/pause control, expiry flag and optional auto-reload.
// All outputs registered; a control or tick sampled at one edge shows on the outputs after that edge.
module bcd_countdown_timer #(
  parameter int DIGITS      = 2,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                start,
  input  logic                pause,
  input  logic                tick,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                expired,
  output logic                done
);

  localparam int W  = 4 * DIGITS;
  localparam bit AR = (AUTO_RELOAD != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t         state;
  logic [W-1:0]   reload;
  logic [W-1:0]   dec;
  logic [W-1:0]   clamped;
  logic           borrow;
  logic [3:0]     cur_digit;
  logic [3:0]     ld_digit;

  // Full-width borrow ripple and load clamping, both settled within the cycle.
  always_comb begin
    dec       = '0;
    clamped   = '0;
    borrow    = 1'b1;
    cur_digit = '0;
    ld_digit  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      cur_digit = count[4*i +: 4];
      ld_digit  = load_value[4*i +: 4];
      if (!borrow) begin
        dec[4*i +: 4] = cur_digit;
      end else if (cur_digit == 4'd0) begin
        dec[4*i +: 4] = 4'd9;
      end else begin
        dec[4*i +: 4] = cur_digit - 4'd1;
        borrow        = 1'b0;
      end
      clamped[4*i +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;
    end
  end

  // Any asserted start blocks pause and tick that cycle, even when start itself is ignored.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      reload  <= '0;
      running <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count   <= clamped;
        reload  <= clamped;
        state   <= IDLE;
        running <= 1'b0;
        expired <= 1'b0;
      end else if (start) begin
        if (state == IDLE || state == PAUSED) begin
          if (count != '0 || AR) begin
            state   <= RUN;
            running <= 1'b1;
          end else begin
            state   <= EXPIRED;
            expired <= 1'b1;
            done    <= 1'b1;
          end
        end
      end else if (pause) begin
        if (state == RUN) begin
          state   <= PAUSED;
          running <= 1'b0;
        end
      end else if (tick && state == RUN) begin
        if (count == '0) begin
          // Only reachable with auto-reload: the tick after reaching zero restarts the phase.
          count <= reload;
          done  <= (reload == '0);
        end else begin
          count <= dec;
          if (dec == '0) begin
            done <= 1'b1;
            if (!AR) begin
              state   <= EXPIRED;
              running <= 1'b0;
              expired <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
